serial_compare_arbiter: RTL and testbench

SERIAL_COMPARE_ARBITER -- requirements
Module: serial_compare_arbiter

---
 rtl/serial_cmp_pkg.sv | 15 +
 rtl/serial_comparator_most_significant_first.sv | 31 +++
 rtl/serial_compare_arbiter.sv | 102 ++++++++++
 tb/tb_serial_compare_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the two-requester serial compare arbiter.
// Holds FSM state encoding, requester id type and requester count.
package serial_cmp_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/serial_comparator_most_significant_first.sv
// Bit-serial unsigned comparator, MSB first.
// Outputs reflect history plus the bit pair presented this cycle.
module serial_comparator_most_significant_first (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  output logic less_o,
  output logic eq_o,
  output logic greater_o
);

  logic lt_q, gt_q;
  logic decided;

  assign decided   = lt_q | gt_q;
  assign less_o    = lt_q | (~decided & ~a_i & b_i);
  assign greater_o = gt_q | (~decided & a_i & ~b_i);
  assign eq_o      = ~less_o & ~greater_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      lt_q <= 1'b0;
      gt_q <= 1'b0;
    end else begin
      lt_q <= less_o;
      gt_q <= greater_o;
    end
  end

endmodule

// File: rtl/serial_compare_arbiter.sv
// Two requesters share one MSB-first serial comparator.
// Round-robin on ties; result held until the consumer takes it.
import serial_cmp_pkg::*;

module serial_compare_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_less,
  output logic             res_eq,
  output logic             res_greater
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  req_id_t          last_q, id_q, grant;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             lt_q, eq_q, gt_q;
  logic             idle, accept, cmp_rst, last_bit;
  logic             cmp_lt, cmp_eq, cmp_gt;

  assign idle     = (state_q == IDLE) && !rst;
  assign grant    = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = idle && req0_valid && !grant;
  assign req1_ready = idle && req1_valid && grant;
  assign accept   = req0_ready | req1_ready;
  assign cmp_rst  = rst | accept;
  assign last_bit = (cnt_q == LAST);

  assign res_valid   = (state_q == DONE) && !rst;
  assign res_id      = id_q;
  assign res_less    = lt_q;
  assign res_eq      = eq_q;
  assign res_greater = gt_q;

  serial_comparator_most_significant_first u_cmp (
    .clk       (clk),
    .rst       (cmp_rst),
    .a_i       (a_q[LAST - cnt_q]),
    .b_i       (b_q[LAST - cnt_q]),
    .less_o    (cmp_lt),
    .eq_o      (cmp_eq),
    .greater_o (cmp_gt)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= grant ? req1_a : req0_a;
        b_q    <= grant ? req1_b : req0_b;
        id_q   <= grant;
        last_q <= grant;
        cnt_q  <= '0;
      end else if (state_q == SHIFT) begin
        // counter parks on the last index instead of wrapping
        if (!last_bit) cnt_q <= cnt_q + CW'(1);
        if (last_bit) begin
          lt_q <= cmp_lt;
          eq_q <= cmp_eq;
          gt_q <= cmp_gt;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Scoreboard bench for serial_compare_arbiter.
// Cycle-level reference model feeds a queue drained by a result monitor.
module tb_serial_compare_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         res_valid, res_ready, res_id;
  logic         res_less, res_eq, res_greater;

  serial_compare_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_less    (res_less),
    .res_eq      (res_eq),
    .res_greater (res_greater)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic id;
    logic lt;
    logic eq;
    logic gt;
    int   t;
  } exp_t;

  exp_t q[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // reference model: idle / busy countdown / waiting for consumer
  int           mst   = 0;
  int           mcnt  = 0;
  logic         mlast = 1'b1;
  logic         mg;
  logic [W-1:0] ma, mb;
  exp_t         me;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_valid", res_valid, 0);
      mst   = 0;
      mlast = 1'b1;
      q.delete();
    end else if (mst == 0) begin
      if (req0_valid && req1_valid) mg = ~mlast;
      else mg = req1_valid;
      chk("rdy0", req0_ready, req0_valid && !mg);
      chk("rdy1", req1_ready, req1_valid && mg);
      chk("idle_valid", res_valid, 0);
      if (req0_valid || req1_valid) begin
        ma    = mg ? req1_a : req0_a;
        mb    = mg ? req1_b : req0_b;
        me.id = mg;
        me.lt = ma < mb;
        me.eq = ma == mb;
        me.gt = ma > mb;
        me.t  = cyc + W + 1;
        q.push_back(me);
        mlast = mg;
        mst   = 1;
        mcnt  = W;
      end
    end else if (mst == 1) begin
      chk("busy_rdy", {req0_ready, req1_ready}, 0);
      chk("busy_valid", res_valid, 0);
      mcnt--;
      if (mcnt == 0) mst = 2;
    end else begin
      chk("done_rdy", {req0_ready, req1_ready}, 0);
      chk("done_valid", res_valid, 1);
      if (res_ready) mst = 0;
    end
  end

  // result monitor
  logic first = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      first = 1'b1;
    end else if (res_valid) begin
      chk("onehot", 64'(res_less) + 64'(res_eq) + 64'(res_greater), 1);
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result cyc=%0d actual=valid required=none", cyc);
      end else begin
        chk("res_id", res_id, q[0].id);
        chk("res_less", res_less, q[0].lt);
        chk("res_eq", res_eq, q[0].eq);
        chk("res_greater", res_greater, q[0].gt);
        if (first) chk("latency", cyc, q[0].t);
        first = 1'b0;
        if (res_ready) begin
          void'(q.pop_front());
          first = 1'b1;
        end
      end
    end
  end

  task automatic drv(logic rs, logic v0, logic [W-1:0] a0, logic [W-1:0] b0,
                     logic v1, logic [W-1:0] a1, logic [W-1:0] b1, logic rr);
    @(posedge clk);
    #1;
    rst        = rs;
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    res_ready  = rr;
  endtask

  task automatic idle(int n);
    repeat (n) drv(0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
  endtask

  task automatic do_rst(int n);
    repeat (n) drv(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
    idle(1);
  endtask

  initial begin
    rst        = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a     = '0;
    req0_b     = '0;
    req1_a     = '0;
    req1_b     = '0;
    res_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_id", res_id, 0);
    chk("reset_flags", {res_less, res_eq, res_greater}, 0);
    chk("reset_valid", res_valid, 0);

    // single requester, equal operands
    drv(0, 1, 8'h5A, 8'h5A, 0, 8'h00, 8'h00, 1);
    idle(12);

    // both valid from reset: req0 first, then req1
    do_rst(2);
    repeat (20) drv(0, 1, 8'h80, 8'h7F, 1, 8'h01, 8'h02, 1);
    idle(12);

    // sustained contention alternates 0,1,0,1
    do_rst(2);
    repeat (40)
      drv(0, 1, 8'($urandom), 8'($urandom), 1, 8'($urandom), 8'($urandom), 1);
    idle(12);

    // consumer stalls in DONE
    repeat (15) drv(0, 1, 8'h33, 8'h44, 1, 8'h55, 8'h66, 0);
    idle(12);

    // operands change after accept
    drv(0, 1, 8'h00, 8'h01, 0, 8'h00, 8'h00, 1);
    repeat (5) drv(0, 1, 8'hFF, 8'h01, 0, 8'h00, 8'h00, 1);
    idle(14);

    // reset in the middle of shifting
    drv(0, 1, 8'h12, 8'h34, 0, 8'h00, 8'h00, 1);
    idle(3);
    drv(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1);
    drv(0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 1);
    idle(12);

    // random traffic with stalls and sporadic resets
    repeat (3000)
      drv($urandom_range(0, 199) == 0,
          1'($urandom), 8'($urandom), 8'($urandom),
          1'($urandom), 8'($urandom), 8'($urandom),
          $urandom_range(0, 3) != 0);
    idle(14);
    @(negedge clk);
    chk("drain", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
